// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings and
// the helpers that turn an op into an operand-B inversion and a carry-in.
package addsub_pipe_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // SUB and SBB add the one's complement of B.
  function automatic logic op_invert_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // ADD/SUB use a fixed carry-in; ADC/SBB take it from the caller
  // (for SBB, in_carry = 1 means no incoming borrow).
  function automatic logic op_cin(input logic [1:0] op, input logic in_carry);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = in_carry;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG-bit slice of the carry chain: purely combinational.
module addsub_seg #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb,
  output logic           zero
);

  logic [SEG:0] full;

  // Slice sum with carry out in the extra bit.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  end

  assign sum   = full[SEG-1:0];
  assign cout  = full[SEG];
  // The carry into the top bit is recovered from that bit's sum equation.
  assign c_msb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];
  assign zero  = ~|sum;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined integer add/subtract with ADC/SBB modes, carry/overflow/zero/
// negative flags and a valid/ready handshake. Stage k resolves segment k of
// the carry chain; every stage advances together when the output is free.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned NSEG = WIDTH / SEG;

  if ((SEG == 0) || ((WIDTH % SEG) != 0)) begin : g_seg_check
    $error("addsub_pipe: WIDTH must be a nonzero multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = op_invert_b(op) ? ~b : b;
  assign cin0     = op_cin(op, in_carry);

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int unsigned LO = k * SEG;
    // B bits not yet consumed when this stage starts (segment k upward).
    localparam int unsigned BW = WIDTH - k * SEG;

    logic             v_in, c_in, z_in;
    logic [WIDTH-1:0] acc_in, acc_nx;
    logic [BW-1:0]    b_in;
    logic [SEG-1:0]   sum;
    logic             cout, c_msb, z_seg;
    logic             v_q, c_q, z_q;
    logic [WIDTH-1:0] acc_q;

    // acc holds finished result segments below LO and untouched A above;
    // each stage overwrites its own segment in place.
    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign c_in   = cin0;
      assign z_in   = 1'b1;
      assign acc_in = a;
      assign b_in   = b_eff;
    end else begin : g_src
      assign v_in   = stg[k-1].v_q;
      assign c_in   = stg[k-1].c_q;
      assign z_in   = stg[k-1].z_q;
      assign acc_in = stg[k-1].acc_q;
      assign b_in   = stg[k-1].g_b.b_q;
    end

    addsub_seg #(.SEG(SEG)) u_seg (
      .a     (acc_in[LO +: SEG]),
      .b     (b_in[SEG-1:0]),
      .cin   (c_in),
      .sum   (sum),
      .cout  (cout),
      .c_msb (c_msb),
      .zero  (z_seg)
    );

    // Splice this stage's sum into the travelling word.
    always_comb begin
      acc_nx            = acc_in;
      acc_nx[LO +: SEG] = sum;
    end

    // Stage register; bubbles advance and freeze exactly like beats.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
        acc_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= cout;
        z_q   <= z_in & z_seg;
        acc_q <= acc_nx;
      end
    end

    if (k < NSEG - 1) begin : g_b
      logic [BW-SEG-1:0] b_q;

      // Skew the remaining B segments forward to the next stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          b_q <= '0;
        end else if (adv) begin
          b_q <= b_in[BW-1:SEG];
        end
      end
    end

    if (k == NSEG - 1) begin : g_top
      logic ov_q;

      // Signed overflow only exists at the top segment.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (adv) begin
          ov_q <= cout ^ c_msb;
        end
      end
    end else begin : g_mid
      logic unused_msb;
      assign unused_msb = c_msb;
    end
  end

  assign out_valid = stg[NSEG-1].v_q;
  assign result    = stg[NSEG-1].acc_q;
  assign carry_out = stg[NSEG-1].c_q;
  assign overflow  = stg[NSEG-1].g_top.ov_q;
  assign zero      = stg[NSEG-1].z_q;
  assign negative  = stg[NSEG-1].acc_q[WIDTH-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: default 32/8 instance plus 16/4 and 32/32.
module tb_addsub_pipe;
  import addsub_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 32-bit, 8-bit segments
  logic        in_valid, in_ready, out_valid, out_ready, in_carry;
  logic        carry_out, overflow, zero, negative;
  logic [31:0] a, b, result;
  logic [1:0]  op;

  // 16-bit, 4-bit segments
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_in_carry;
  logic        h_carry_out, h_overflow, h_zero, h_negative;
  logic [15:0] h_a, h_b, h_result;
  logic [1:0]  h_op;

  // 32-bit, single segment
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_in_carry;
  logic        s_carry_out, s_overflow, s_zero, s_negative;
  logic [31:0] s_a, s_b, s_result;
  logic [1:0]  s_op;

  addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative)
  );

  addsub_pipe #(.WIDTH(16), .SEG(4)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .op(h_op), .in_carry(h_in_carry),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .carry_out(h_carry_out), .overflow(h_overflow), .zero(h_zero), .negative(h_negative)
  );

  addsub_pipe #(.WIDTH(32), .SEG(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .op(s_op), .in_carry(s_in_carry),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .carry_out(s_carry_out), .overflow(s_overflow), .zero(s_zero), .negative(s_negative)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat through the 32/8 unit with out_ready held high.
  task automatic send_check(input string tag, input logic [1:0] o,
                            input logic [31:0] x, input logic [31:0] y, input logic ci,
                            input logic [31:0] er, input logic ec, input logic eov,
                            input logic ez, input logic en);
    int cyc;
    op = o; a = x; b = y; in_carry = ci; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, cyc, 4);
    check({tag, ".result"}, result, er);
    check({tag, ".carry"}, carry_out, ec);
    check({tag, ".ovf"}, overflow, eov);
    check({tag, ".zero"}, zero, ez);
    check({tag, ".neg"}, negative, en);
    tick();
    check({tag, ".drained"}, out_valid, 0);
  endtask

  typedef struct packed {
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  vec_t sv [6];

  initial begin
    int sent, got, cyc, stall_left, seen;
    logic stalled;

    sv[0] = '{OP_ADD, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0};
    sv[1] = '{OP_SUB, 32'h00000003, 32'h00000003, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    sv[2] = '{OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
    sv[3] = '{OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    sv[4] = '{OP_ADC, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    sv[5] = '{OP_SBB, 32'h00000010, 32'h00000001, 1'b0, 32'h0000000E, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = '0; b = '0; op = OP_ADD; in_carry = 0;
    h_in_valid = 0; h_out_ready = 0; h_a = '0; h_b = '0; h_op = OP_ADD; h_in_carry = 0;
    s_in_valid = 0; s_out_ready = 0; s_a = '0; s_b = '0; s_op = OP_ADD; s_in_carry = 0;
    tick();
    tick();
    rst_n = 1'b1;

    check("reset.out_valid", out_valid, 0);
    check("reset.result", result, 0);
    check("reset.flags", {carry_out, overflow, zero, negative}, 4'b0000);
    check("reset.in_ready", in_ready, 1);
    check("reset.h_out_valid", h_out_valid, 0);
    check("reset.s_out_valid", s_out_valid, 0);

    send_check("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 0, 1, 0, 1);
    send_check("sub_eq",   OP_SUB, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1, 0, 1, 0);
    send_check("sub_brw",  OP_SUB, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1);
    send_check("chain_lo", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1, 0, 1, 0);
    send_check("chain_hi", OP_ADC, 32'h00000001, 32'h00000000, 1'b1, 32'h00000002, 0, 0, 0, 0);
    send_check("sbb",      OP_SBB, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1);
    send_check("add_ign",  OP_ADD, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 0, 0, 0, 0);
    send_check("sub_ign",  OP_SUB, 32'h00000010, 32'h00000003, 1'b0, 32'h0000000D, 1, 0, 0, 0);

    // Back-to-back beats with a 3-cycle consumer stall at the first result.
    sent = 0; got = 0; cyc = 0; stall_left = 0; stalled = 1'b0;
    while (got < 6 && cyc < 60) begin
      if (out_valid && !stalled) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      if (sent < 6) begin
        in_valid = 1'b1; op = sv[sent].o; a = sv[sent].x; b = sv[sent].y; in_carry = sv[sent].ci;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        check("stall.out_valid", out_valid, 1);
        check("stall.result", result, sv[got].r);
        check("stall.in_ready", in_ready, 0);
        stall_left--;
      end else if (out_valid) begin
        check($sformatf("stream%0d.result", got), result, sv[got].r);
        check($sformatf("stream%0d.carry", got), carry_out, sv[got].c);
        check($sformatf("stream%0d.ovf", got), overflow, sv[got].v);
        check($sformatf("stream%0d.zero", got), zero, sv[got].z);
        check($sformatf("stream%0d.neg", got), negative, sv[got].n);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream.count", got, 6);
    tick();
    check("stream.empty", out_valid, 0);

    // Reset with three beats in flight: none may ever emerge.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = OP_ADD; a = 32'(i + 1); b = 32'(i + 1); in_carry = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.result", result, 0);
    check("midrst.flags", {carry_out, overflow, zero, negative}, 4'b0000);
    check("midrst.in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst.ghosts", seen, 0);
    send_check("post_rst", OP_ADD, 32'h00000100, 32'h00000023, 1'b0, 32'h00000123, 0, 0, 0, 0);

    // 16-bit / 4-bit segments: SUB 0x8000 - 1.
    h_op = OP_SUB; h_a = 16'h8000; h_b = 16'h0001; h_in_valid = 1'b1; h_out_ready = 1'b1;
    tick();
    h_in_valid = 1'b0;
    cyc = 1;
    while (!h_out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("w16.latency", cyc, 4);
    check("w16.result", h_result, 16'h7FFF);
    check("w16.ovf", h_overflow, 1);
    check("w16.carry", h_carry_out, 1);
    check("w16.zero", h_zero, 0);
    check("w16.neg", h_negative, 0);

    // Single segment: latency 1.
    s_op = OP_ADD; s_a = 32'd3; s_b = 32'd4; s_in_valid = 1'b1; s_out_ready = 1'b1;
    tick();
    s_in_valid = 1'b0;
    cyc = 1;
    while (!s_out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("seg1.latency", cyc, 1);
    check("seg1.result", s_result, 32'd7);
    check("seg1.flags", {s_carry_out, s_overflow, s_zero, s_negative}, 4'b0000);
    tick();
    check("seg1.drained", s_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
